// File: rtl/mem_line_bridge_if.sv
// Signal bundle between the L1 memory arbiter, mem_line_bridge and the external
// narrow-beat memory port. slave = bridge view, master = environment view.
interface mem_line_bridge_if #(
    parameter int ADDR_BITS = 64,
    parameter int LINE_BITS = 128,
    parameter int BEAT_BITS = 32,
    parameter int TAG_BITS  = 2
) ();
    logic                 mem_req_valid;
    logic [ADDR_BITS-1:0] mem_req_addr;
    logic [LINE_BITS-1:0] mem_req_store_data;
    logic [TAG_BITS-1:0]  mem_req_tag;
    logic [4:0]           mem_req_opcode;
    logic                 mem_req_ack;
    logic                 mem_rsp_valid;
    logic [LINE_BITS-1:0] mem_rsp_load_data;
    logic [TAG_BITS-1:0]  mem_rsp_tag;
    logic [4:0]           mem_rsp_opcode;

    logic                 ext_cmd_valid;
    logic                 ext_cmd_ready;
    logic [ADDR_BITS-1:0] ext_cmd_addr;
    logic                 ext_cmd_we;
    logic                 ext_wdata_valid;
    logic                 ext_wdata_ready;
    logic [BEAT_BITS-1:0] ext_wdata;
    logic                 ext_rdata_valid;
    logic [BEAT_BITS-1:0] ext_rdata;

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_store_data, mem_req_tag, mem_req_opcode,
        output mem_req_ack, mem_rsp_valid, mem_rsp_load_data, mem_rsp_tag, mem_rsp_opcode,
        output ext_cmd_valid, ext_cmd_addr, ext_cmd_we, ext_wdata_valid, ext_wdata,
        input  ext_cmd_ready, ext_wdata_ready, ext_rdata_valid, ext_rdata
    );

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_store_data, mem_req_tag, mem_req_opcode,
        input  mem_req_ack, mem_rsp_valid, mem_rsp_load_data, mem_rsp_tag, mem_rsp_opcode,
        input  ext_cmd_valid, ext_cmd_addr, ext_cmd_we, ext_wdata_valid, ext_wdata,
        output ext_cmd_ready, ext_wdata_ready, ext_rdata_valid, ext_rdata
    );
endinterface

// File: rtl/mem_line_bridge.sv
// Terminates the arbiter's line-granular port: one line request becomes a command
// plus a burst of narrow beats; read beats are reassembled into a tagged response.
module mem_line_bridge #(
    parameter int             ADDR_BITS = 64,
    parameter int             LINE_BITS = 128,
    parameter int             BEAT_BITS = 32,
    parameter int             TAG_BITS  = 2,
    parameter logic [4:0]     OP_STORE  = 5'd7
) (
    input  logic              clk,
    input  logic              reset,
    mem_line_bridge_if.slave  bus,
    output logic              busy,
    output logic              protocol_err
);
    localparam int NBEATS = LINE_BITS / BEAT_BITS;
    localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int OFF    = $clog2(LINE_BITS / 8);
    localparam logic [CW-1:0] LAST = CW'(NBEATS - 1);

    typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, RSP} state_t;

    state_t                             state;
    logic [CW-1:0]                      cnt;
    logic [NBEATS-1:0][BEAT_BITS-1:0]   line_q;
    logic [ADDR_BITS-1:0]               addr_q;
    logic [TAG_BITS-1:0]                tag_q;
    logic [4:0]                         op_q;
    logic                               we_q;

    wire last = (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            line_q       <= '0;
            addr_q       <= '0;
            tag_q        <= '0;
            op_q         <= '0;
            we_q         <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            if (bus.ext_rdata_valid && state != RDATA)
                protocol_err <= 1'b1;
            case (state)
                IDLE: if (bus.mem_req_valid) begin
                    addr_q <= {bus.mem_req_addr[ADDR_BITS-1:OFF], OFF'(0)};
                    tag_q  <= bus.mem_req_tag;
                    op_q   <= bus.mem_req_opcode;
                    we_q   <= (bus.mem_req_opcode == OP_STORE);
                    line_q <= bus.mem_req_store_data;
                    cnt    <= '0;
                    state  <= CMD;
                end
                CMD: if (bus.ext_cmd_ready) begin
                    cnt   <= '0;
                    state <= we_q ? WDATA : RDATA;
                end
                WDATA: if (bus.ext_wdata_ready) begin
                    cnt <= last ? '0 : cnt + 1'b1;
                    if (last) state <= RSP;
                end
                RDATA: if (bus.ext_rdata_valid) begin
                    line_q[cnt] <= bus.ext_rdata;
                    cnt         <= last ? '0 : cnt + 1'b1;
                    if (last) state <= RSP;
                end
                RSP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // ack must land in the capture cycle itself, so it is the only output
    // that depends on an input; gated by reset so it stays 0 while held.
    assign bus.mem_req_ack       = reset && (state == IDLE) && bus.mem_req_valid;

    assign bus.ext_cmd_valid     = (state == CMD);
    assign bus.ext_cmd_addr      = (state == CMD) ? addr_q : '0;
    assign bus.ext_cmd_we        = (state == CMD) && we_q;
    assign bus.ext_wdata_valid   = (state == WDATA);
    assign bus.ext_wdata         = (state == WDATA) ? line_q[cnt] : '0;

    assign bus.mem_rsp_valid     = (state == RSP);
    assign bus.mem_rsp_load_data = (state == RSP && !we_q) ? line_q : '0;
    assign bus.mem_rsp_tag       = (state == RSP) ? tag_q : '0;
    assign bus.mem_rsp_opcode    = (state == RSP) ? op_q : '0;

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_mem_line_bridge.sv
// Directed bench for mem_line_bridge: read, stalled write, command stall,
// back-to-back, spurious beat and mid-burst reset, all against fixed vectors.
module tb_mem_line_bridge;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic busy, protocol_err;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_line_bridge_if bus ();

    mem_line_bridge dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .busy         (busy),
        .protocol_err (protocol_err)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.mem_req_valid      = 1'b0;
        bus.mem_req_addr       = '0;
        bus.mem_req_store_data = '0;
        bus.mem_req_tag        = '0;
        bus.mem_req_opcode     = '0;
        bus.ext_cmd_ready      = 1'b0;
        bus.ext_wdata_ready    = 1'b0;
        bus.ext_rdata_valid    = 1'b0;
        bus.ext_rdata          = '0;
    endtask

    // Issue a read, optionally stall the command, feed 4 beats, check the response.
    task automatic rd(input logic [63:0] a, input logic [63:0] exp_addr, input logic [1:0] tg,
                      input logic [4:0] op, input logic [3:0][31:0] bt,
                      input logic [127:0] exp_line, input int stall);
        int lat;
        @(negedge clk);
        bus.mem_req_valid  = 1'b1;
        bus.mem_req_addr   = a;
        bus.mem_req_tag    = tg;
        bus.mem_req_opcode = op;
        #1 chk("rd_ack", bus.mem_req_ack, 1'b1);
        lat = 0;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk); lat++;
            bus.ext_cmd_ready = 1'b0;
            #1;
            chk("stall_cmd_valid", bus.ext_cmd_valid, 1'b1);
            chk("stall_addr", bus.ext_cmd_addr, exp_addr);
            chk("stall_no_ack", bus.mem_req_ack, 1'b0);
        end
        @(negedge clk); lat++;
        bus.ext_cmd_ready = 1'b1;
        #1;
        chk("rd_cmd_valid", bus.ext_cmd_valid, 1'b1);
        chk("rd_cmd_addr", bus.ext_cmd_addr, exp_addr);
        chk("rd_cmd_we", bus.ext_cmd_we, 1'b0);
        chk("rd_no_ack", bus.mem_req_ack, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); lat++;
            bus.ext_cmd_ready   = 1'b0;
            bus.ext_rdata_valid = 1'b1;
            bus.ext_rdata       = bt[i];
            #1 chk("rd_no_rsp", bus.mem_rsp_valid, 1'b0);
        end
        @(negedge clk); lat++;
        bus.ext_rdata_valid = 1'b0;
        bus.ext_rdata       = '0;
        #1;
        chk("rd_rsp_valid", bus.mem_rsp_valid, 1'b1);
        chk("rd_rsp_data", bus.mem_rsp_load_data, exp_line);
        chk("rd_rsp_tag", bus.mem_rsp_tag, tg);
        chk("rd_rsp_op", bus.mem_rsp_opcode, op);
        chk("rd_latency", lat, 6 + stall);
        bus.mem_req_valid = 1'b0;
        #1 chk("rsp_no_ack", bus.mem_req_ack, 1'b0);
    endtask

    initial begin
        logic [3:0][31:0] bt;
        logic [31:0] wexp [4];
        int b, t, lat;

        idle_inputs();
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_ack", bus.mem_req_ack, 1'b0);
        chk("rst_rsp_valid", bus.mem_rsp_valid, 1'b0);
        chk("rst_cmd_valid", bus.ext_cmd_valid, 1'b0);
        chk("rst_err", protocol_err, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // basic read
        bt = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        rd(64'h1234, 64'h1230, 2'd2, 5'd4, bt,
           128'h44444444_33333333_22222222_11111111, 0);
        @(negedge clk);
        #1;
        chk("post_rd_rsp", bus.mem_rsp_valid, 1'b0);
        chk("post_rd_data", bus.mem_rsp_load_data, 128'h0);
        chk("post_rd_busy", busy, 1'b0);

        // write with wdata_ready toggling 1,0,1,0,...
        bus.mem_req_valid      = 1'b1;
        bus.mem_req_addr       = 64'hABCD_0000_0000_567F;
        bus.mem_req_store_data = 128'hDDDD_CCCC_BBBB_AAAA;
        bus.mem_req_tag        = 2'd1;
        bus.mem_req_opcode     = 5'd7;
        #1 chk("wr_ack", bus.mem_req_ack, 1'b1);
        wexp = '{32'hBBBBAAAA, 32'hDDDDCCCC, 32'h0, 32'h0};
        @(negedge clk);
        bus.ext_cmd_ready = 1'b1;
        #1;
        chk("wr_cmd_we", bus.ext_cmd_we, 1'b1);
        chk("wr_cmd_addr", bus.ext_cmd_addr, 64'hABCD_0000_0000_5670);
        lat = 1; b = 0; t = 0;
        while (b < 4 && t < 20) begin
            @(negedge clk); lat++;
            bus.ext_cmd_ready   = 1'b0;
            bus.ext_wdata_ready = (t % 2 == 0);
            #1;
            chk("wr_wvalid", bus.ext_wdata_valid, 1'b1);
            chk("wr_wdata", bus.ext_wdata, wexp[b]);
            if (bus.ext_wdata_ready) b++;
            t++;
        end
        @(negedge clk); lat++;
        bus.ext_wdata_ready = 1'b0;
        #1;
        chk("wr_rsp_valid", bus.mem_rsp_valid, 1'b1);
        chk("wr_rsp_data", bus.mem_rsp_load_data, 128'h0);
        chk("wr_rsp_tag", bus.mem_rsp_tag, 2'd1);
        chk("wr_rsp_op", bus.mem_rsp_opcode, 5'd7);
        chk("wr_latency", lat, 9);
        bus.mem_req_valid = 1'b0;
        bus.mem_req_store_data = '0;

        // back-to-back: new read in the IDLE cycle right after RSP, with a command stall
        bt = {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};
        rd(64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFF0, 2'd3, 5'd0, bt,
           128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 10);
        rd(64'h40, 64'h40, 2'd0, 5'd1, {32'h4, 32'h3, 32'h2, 32'h1},
           128'h00000004_00000003_00000002_00000001, 0);

        // spurious read beat in IDLE
        @(negedge clk);
        bus.ext_rdata_valid = 1'b1;
        bus.ext_rdata       = 32'h5A5A5A5A;
        @(negedge clk);
        bus.ext_rdata_valid = 1'b0;
        #1;
        chk("spur_err", protocol_err, 1'b1);
        chk("spur_busy", busy, 1'b0);
        rd(64'h80, 64'h80, 2'd1, 5'd2, {32'hA4, 32'hA3, 32'hA2, 32'hA1},
           128'h000000A4_000000A3_000000A2_000000A1, 0);
        chk("spur_err_sticky", protocol_err, 1'b1);

        // reset after two read beats
        @(negedge clk);
        bus.mem_req_valid  = 1'b1;
        bus.mem_req_addr   = 64'h100;
        bus.mem_req_tag    = 2'd2;
        bus.mem_req_opcode = 5'd3;
        @(negedge clk);
        bus.ext_cmd_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.ext_cmd_ready   = 1'b0;
            bus.ext_rdata_valid = 1'b1;
            bus.ext_rdata       = 32'hEE00 + i;
        end
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        #1;
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_ack", bus.mem_req_ack, 1'b0);
        chk("mrst_rsp", bus.mem_rsp_valid, 1'b0);
        chk("mrst_rsp_data", bus.mem_rsp_load_data, 128'h0);
        chk("mrst_cmd", bus.ext_cmd_valid, 1'b0);
        chk("mrst_err", protocol_err, 1'b0);
        @(negedge clk);
        #1 chk("mrst_no_rsp", bus.mem_rsp_valid, 1'b0);
        reset = 1'b1;
        rd(64'h208, 64'h200, 2'd3, 5'd4, {32'hB4, 32'hB3, 32'hB2, 32'hB1},
           128'h000000B4_000000B3_000000B2_000000B1, 0);
        chk("final_err", protocol_err, 1'b0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
